// File: rtl/load_store_unit.sv
// Load/store stage: turns an ALU byte address plus rs2 data into a word-addressed
// req/ack memory access. Stores get lane-replicated data and byte strobes. Loads get
// an aligned, sign- or zero-extended result. Faults: misaligned, illegal width, timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  logic        req_illegal;
  logic        req_misaligned;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] rdata_shift;
  logic [31:0] load_ext;

  // Decode the incoming request: legality, alignment and store lane placement.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    req_wdata      = store_data;
    req_wstrb      = 4'b0000;
    if (is_store) begin
      req_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
    end else begin
      req_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                      funct3 == 3'b100 || funct3 == 3'b101);
    end
    case (funct3[1:0])
      2'b01:   req_misaligned = addr[0];
      2'b10:   req_misaligned = (addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          req_wdata = {4{store_data[7:0]}};
          req_wstrb = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          req_wdata = {2{store_data[15:0]}};
          req_wstrb = 4'b0011 << addr[1:0];
        end
        default: begin
          req_wdata = store_data;
          req_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Pull the addressed byte/half down to bit 0 and extend it per the latched width.
  always_comb begin
    rdata_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_ext = {24'b0, rdata_shift[7:0]};
      3'b101:  load_ext = {16'b0, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  // Next-state logic: check on the start edge, wait for ack or timeout, pulse done.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    cause_d     = cause_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d  = is_store;
          funct3_d    = funct3;
          addr_d      = addr;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          cnt_d       = '0;
          load_data_d = 32'h0;
          fault_d     = 1'b0;
          cause_d     = 2'b00;
          if (req_illegal) begin
            fault_d = 1'b1;
            cause_d = 2'b11;
            state_d = S_RESP;
          end else if (req_misaligned) begin
            fault_d = 1'b1;
            cause_d = 2'b01;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (!is_store_q) begin
            load_data_d = load_ext;
          end
          cnt_d   = '0;
          state_d = S_RESP;
        end else if (cnt_q + CW'(1) == CW'(TIMEOUT_CYCLES)) begin
          cnt_d   = '0;
          fault_d = 1'b1;
          cause_d = 2'b10;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'b0000;
      cnt_q       <= '0;
      load_data_q <= 32'h0;
      fault_q     <= 1'b0;
      cause_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_RESP);
  assign load_data   = load_data_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign mem_req     = (state_q == S_REQ);
  assign mem_we      = (state_q == S_REQ) && is_store_q;
  assign mem_addr    = {addr_q[31:2], 2'b00};
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = (state_q == S_REQ) ? wstrb_q : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized accesses checked against
// a byte-level reference model of the access rules.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .fault(fault), .fault_cause(fault_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Free-running clock; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // One complete access, with the memory acking after 'waits' REQ cycles (negative = never).
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rd, input int waits);
    int size, off, cyc, reqs, exp_reqs;
    logic legal, mis, exp_fault, timed_out, got;
    logic [1:0]  exp_cause;
    logic [31:0] exp_wdata, exp_ld;
    logic [3:0]  exp_wstrb;
    logic [68:0] exp_req, act_req;
    longint v, one;
    one  = 1;
    size = 1 << f3[1:0];
    off  = a % 4;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = (off % size) != 0;
    exp_fault = !legal || mis;
    exp_cause = !legal ? 2'b11 : (mis ? 2'b01 : 2'b00);
    exp_ld = 32'h0;
    for (int i = 0; i < 4; i++) begin
      exp_wdata[8*i +: 8] = st ? sd[8*(i % size) +: 8] : 8'h00;
      exp_wstrb[i] = st && (i >= off) && (i < off + size);
    end
    if (!st && !exp_fault) begin
      v = (longint'(rd) >> (8*off)) & ((one << (8*size)) - 1);
      if (!f3[2] && size < 4 && v >= (one << (8*size - 1))) v = v - (one << (8*size));
      exp_ld = v[31:0];
    end
    timed_out = !exp_fault && (waits < 0 || waits >= TO);
    if (exp_fault)      exp_reqs = 0;
    else if (timed_out) exp_reqs = TO;
    else                exp_reqs = waits + 1;
    if (timed_out) begin
      exp_fault = 1'b1;
      exp_cause = 2'b10;
    end
    exp_req = {st, a[31:2], 2'b00, exp_wstrb, exp_wdata};

    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; mem_ack = 1'b0;
    cyc = 0; reqs = 0; got = 1'b0;
    while (!got && cyc < TO + 20) begin
      @(negedge clk);
      start = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom; cyc++;
      if (done) begin
        got = 1'b1;
      end else if (mem_req) begin
        act_req = {mem_we, mem_addr, mem_wstrb, st ? mem_wdata : 32'h0};
        total++;
        if (act_req !== exp_req) begin
          bad++;
          $display("[TB] FAIL req_fields: got %h want %h", act_req, exp_req);
        end
        if (reqs == waits) begin
          mem_ack = 1'b1; mem_rdata = rd;
        end
        reqs++;
      end
    end
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("[TB] FAIL done_seen: got %0b want 1 after %0d cycles", got, cyc);
    end
    total++;
    if (cyc !== exp_reqs + 1) begin
      bad++;
      $display("[TB] FAIL latency: got %0d want %0d", cyc, exp_reqs + 1);
    end
    total++;
    if (reqs !== exp_reqs) begin
      bad++;
      $display("[TB] FAIL req_cycles: got %0d want %0d", reqs, exp_reqs);
    end
    total++;
    if ({fault, fault_cause, mem_req} !== {exp_fault, exp_cause, 1'b0}) begin
      bad++;
      $display("[TB] FAIL status: got fault=%0b cause=%b req=%0b want fault=%0b cause=%b req=0",
               fault, fault_cause, mem_req, exp_fault, exp_cause);
    end
    if (!st && !exp_fault) begin
      total++;
      if (load_data !== exp_ld) begin
        bad++;
        $display("[TB] FAIL load_data: got %h want %h", load_data, exp_ld);
      end
    end
    @(negedge clk);
    total++;
    if ({done, busy, fault, fault_cause} !== {1'b0, 1'b0, exp_fault, exp_cause}) begin
      bad++;
      $display("[TB] FAIL after_done: got done=%0b busy=%0b fault=%0b cause=%b want 0 0 %0b %b",
               done, busy, fault, fault_cause, exp_fault, exp_cause);
    end
  endtask

  // Reset state of every output.
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, fault, fault_cause, mem_req, mem_we, mem_wstrb} !== 10'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b want 0", {busy, done, fault, fault_cause, mem_req, mem_we, mem_wstrb});
    end
    total++;
    if ({load_data, mem_addr, mem_wdata} !== 96'h0) begin
      bad++;
      $display("[TB] FAIL reset_data: got %h want 0", {load_data, mem_addr, mem_wdata});
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, mem_req} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL idle_after_reset: got %b want 000", {busy, done, mem_req});
    end
  endtask

  // Worked examples plus fault priority and illegal widths.
  task automatic test_directed();
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    total++;
    if (load_data !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL lw_value: got %h want deadbeef", load_data);
    end
    run_access(1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0);
    run_access(1'b0, 3'b000, 32'h3, 32'h0, 32'h80FF0000, 1);
    total++;
    if (load_data !== 32'hFFFFFF80) begin
      bad++; $display("[TB] FAIL lb_value: got %h want ffffff80", load_data);
    end
    run_access(1'b0, 3'b101, 32'h2, 32'h0, 32'h80FF0000, 0);
    total++;
    if (load_data !== 32'h000080FF) begin
      bad++; $display("[TB] FAIL lhu_value: got %h want 000080ff", load_data);
    end
    run_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    run_access(1'b0, 3'b001, 32'h10, 32'h0, 32'h0, -1);
    run_access(1'b1, 3'b001, 32'h206, 32'h1234BEEF, 32'h0, 2);
    run_access(1'b1, 3'b011, 32'h101, 32'h0, 32'h0, 0);
    run_access(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 0);
    run_access(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    run_access(1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 0);
  endtask

  // Randomized accesses, back to back, biased toward legal widths.
  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a;
    logic st;
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & ~(32'h1 << f3[1:0]) & 32'hFFFFFFFC | (a & 32'h3 & ~((32'h1 << f3[1:0]) - 1));
      run_access(st, f3, a, $urandom, $urandom, $urandom_range(0, 6) - 1);
    end
  endtask

  // A start pulse during REQ is dropped and never turns into a second access.
  task automatic test_busy_ignore();
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h80; store_data = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
      bad++;
      $display("[TB] FAIL busy_start_req: got %b %b %h want 1 0 00000040", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    total++;
    if ({done, fault, load_data} !== {1'b1, 1'b0, 32'h12345678}) begin
      bad++;
      $display("[TB] FAIL busy_done: got %b %b %h want 1 0 12345678", done, fault, load_data);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({busy, mem_req, done} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL no_queued_access: got %b want 000", {busy, mem_req, done});
      end
    end
  endtask

  // Ack while idle has no effect.
  task automatic test_ack_outside();
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({busy, done, load_data} !== {2'b00, 32'h12345678}) begin
        bad++;
        $display("[TB] FAIL idle_ack: got %b %b %h want 0 0 12345678", busy, done, load_data);
      end
    end
    mem_ack = 1'b0;
  endtask

  // Reset pulled low mid-REQ abandons the access without a done pulse.
  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b001; addr = 32'h10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1) begin
      bad++; $display("[TB] FAIL mid_req_active: got %b want 1", mem_req);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_req, busy, done, fault} !== 4'b0000) begin
      bad++; $display("[TB] FAIL mid_reset: got %b want 0000", {mem_req, busy, done, fault});
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({mem_req, busy, done} !== 3'b000) begin
        bad++; $display("[TB] FAIL post_mid_reset: got %b want 000", {mem_req, busy, done});
      end
    end
  endtask

  // Test sequence and summary.
  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_ack_outside();
    test_random();
    test_reset_mid();
    run_access(1'b0, 3'b100, 32'h7, 32'h0, 32'h9A000000, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
